// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder
//   Decodes command frames from the UART_RX byte stream into one-cycle register-file
//   write/read strobes and ALU-start strobes. Same clock domain as UART_RX, no backpressure.
//
//   Frames (first byte is the opcode):
//     0xAA addr data    -> wr_en  with addr / wr_data
//     0xBB addr         -> rd_en  with addr
//     0xCC A B fun      -> wr_en addr=0 data=A, wr_en addr=1 data=B, alu_en with alu_fun
//     0xDD fun          -> alu_en with alu_fun
//   Any other opcode gives a one-cycle cmd_err pulse.
//
//   Ports:
//     CLK        in   system clock, rising edge
//     RST        in   asynchronous active-low reset
//     rx_p_data  in   received byte
//     rx_d_valid in   byte valid, one byte per high cycle
//     wr_en      out  register write strobe
//     rd_en      out  register read strobe
//     addr       out  write/read address, held between strobes
//     wr_data    out  write data, held between strobes
//     alu_en     out  ALU start strobe
//     alu_fun    out  ALU function, held between strobes
//     cmd_err    out  bad opcode or frame timeout pulse
//
//   Optional feature: define RX_CMD_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
//   consecutive idle cycles mid-frame. Without it the FSM waits indefinitely.
module rx_cmd_decoder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      rx_p_data,
  input  logic                  rx_d_valid,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  cmd_err
);

  localparam logic [WIDTH-1:0] OpWrite  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] OpRead   = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] OpAluOps = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] OpAluFun = WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StAluA,
    StAluB,
    StAluFun
  } state_e;

  state_e                r_state,    w_state_d;
  logic                  r_wr_en,    w_wr_en_d;
  logic                  r_rd_en,    w_rd_en_d;
  logic                  r_alu_en,   w_alu_en_d;
  logic                  r_cmd_err,  w_cmd_err_d;
  logic [ADDR_WIDTH-1:0] r_addr,     w_addr_d;
  logic [ADDR_WIDTH-1:0] r_cap_addr, w_cap_addr_d;
  logic [WIDTH-1:0]      r_wr_data,  w_wr_data_d;
  logic [FUN_WIDTH-1:0]  r_alu_fun,  w_alu_fun_d;
  logic                  w_tmo_expire;

`ifdef RX_CMD_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TmoLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt, w_tmo_cnt_d;

  // The counter holds the number of idle cycles already seen, so expiry fires on the
  // TIMEOUT_CYCLES-th idle cycle; a byte arriving in that cycle wins over the timeout.
  always_comb begin
    w_tmo_expire = (r_state != StIdle) && !rx_d_valid && (r_tmo_cnt == TmoLast);
    w_tmo_cnt_d  = r_tmo_cnt;
    if (rx_d_valid || (r_state == StIdle)) begin
      w_tmo_cnt_d = '0;
    end else if (r_tmo_cnt != '1) begin
      w_tmo_cnt_d = r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_d;
    end
  end
`else
  assign w_tmo_expire = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_wr_en_d    = 1'b0;
    w_rd_en_d    = 1'b0;
    w_alu_en_d   = 1'b0;
    w_cmd_err_d  = 1'b0;
    w_addr_d     = r_addr;
    w_cap_addr_d = r_cap_addr;
    w_wr_data_d  = r_wr_data;
    w_alu_fun_d  = r_alu_fun;

    if (rx_d_valid) begin
      unique case (r_state)
        StIdle: begin
          if (rx_p_data == OpWrite) begin
            w_state_d = StWrAddr;
          end else if (rx_p_data == OpRead) begin
            w_state_d = StRdAddr;
          end else if (rx_p_data == OpAluOps) begin
            w_state_d = StAluA;
          end else if (rx_p_data == OpAluFun) begin
            w_state_d = StAluFun;
          end else begin
            w_cmd_err_d = 1'b1;
          end
        end
        StWrAddr: begin
          // Address is held internally so addr only changes when wr_en fires.
          w_cap_addr_d = rx_p_data[ADDR_WIDTH-1:0];
          w_state_d    = StWrData;
        end
        StWrData: begin
          w_wr_en_d   = 1'b1;
          w_addr_d    = r_cap_addr;
          w_wr_data_d = rx_p_data;
          w_state_d   = StIdle;
        end
        StRdAddr: begin
          w_rd_en_d = 1'b1;
          w_addr_d  = rx_p_data[ADDR_WIDTH-1:0];
          w_state_d = StIdle;
        end
        StAluA: begin
          w_wr_en_d   = 1'b1;
          w_addr_d    = ADDR_WIDTH'(0);
          w_wr_data_d = rx_p_data;
          w_state_d   = StAluB;
        end
        StAluB: begin
          w_wr_en_d   = 1'b1;
          w_addr_d    = ADDR_WIDTH'(1);
          w_wr_data_d = rx_p_data;
          w_state_d   = StAluFun;
        end
        StAluFun: begin
          w_alu_en_d  = 1'b1;
          w_alu_fun_d = rx_p_data[FUN_WIDTH-1:0];
          w_state_d   = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end else if (w_tmo_expire) begin
      w_state_d   = StIdle;
      w_cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= StIdle;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_alu_en   <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_addr     <= '0;
      r_cap_addr <= '0;
      r_wr_data  <= '0;
      r_alu_fun  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_wr_en    <= w_wr_en_d;
      r_rd_en    <= w_rd_en_d;
      r_alu_en   <= w_alu_en_d;
      r_cmd_err  <= w_cmd_err_d;
      r_addr     <= w_addr_d;
      r_cap_addr <= w_cap_addr_d;
      r_wr_data  <= w_wr_data_d;
      r_alu_fun  <= w_alu_fun_d;
    end
  end

  assign wr_en   = r_wr_en;
  assign rd_en   = r_rd_en;
  assign alu_en  = r_alu_en;
  assign cmd_err = r_cmd_err;
  assign addr    = r_addr;
  assign wr_data = r_wr_data;
  assign alu_fun = r_alu_fun;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb_rx_cmd_decoder
//   Directed byte frames into rx_cmd_decoder. A frame-level model (queue of bytes of the
//   frame in progress, decoded by opcode and frame length) predicts every output each cycle;
//   a strobe log feeds literal per-test expectations. Define RX_CMD_TIMEOUT_EN to add the
//   timeout tests (TIMEOUT_CYCLES = 20).
module tb_rx_cmd_decoder;

`ifdef RX_CMD_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 5000;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_p_data;
  logic       rx_d_valid;
  logic       wr_en, rd_en, alu_en, cmd_err;
  logic [3:0] addr;
  logic [7:0] wr_data;
  logic [3:0] alu_fun;

  rx_cmd_decoder #(
    .WIDTH         (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_WIDTH (16),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .CLK       (clk),
    .RST       (rst_n),
    .rx_p_data (rx_p_data),
    .rx_d_valid(rx_d_valid),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .alu_en    (alu_en),
    .alu_fun   (alu_fun),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0] frame[$];
  int         idle_cnt = 0;
  logic       e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0;
  logic [3:0] e_addr = 0, e_fun = 0;
  logic [7:0] e_data = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      frame.delete();
      idle_cnt = 0;
      {e_wr, e_rd, e_alu, e_err} = '0;
      e_addr = 0; e_data = 0; e_fun = 0;
    end else begin
      {e_wr, e_rd, e_alu, e_err} = '0;
      if (rx_d_valid) begin
        idle_cnt = 0;
        if (frame.size() == 0) begin
          if (rx_p_data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) frame.push_back(rx_p_data);
          else e_err = 1;
        end else begin
          frame.push_back(rx_p_data);
          case (frame[0])
            8'hAA: if (frame.size() == 3) begin
              e_wr = 1; e_addr = frame[1][3:0]; e_data = frame[2]; frame.delete();
            end
            8'hBB: begin
              e_rd = 1; e_addr = frame[1][3:0]; frame.delete();
            end
            8'hCC: begin
              if (frame.size() == 2) begin e_wr = 1; e_addr = 0; e_data = frame[1]; end
              else if (frame.size() == 3) begin e_wr = 1; e_addr = 1; e_data = frame[2]; end
              else begin e_alu = 1; e_fun = frame[3][3:0]; frame.delete(); end
            end
            default: begin
              e_alu = 1; e_fun = frame[1][3:0]; frame.delete();
            end
          endcase
        end
      end else if (frame.size() != 0) begin
        idle_cnt++;
`ifdef RX_CMD_TIMEOUT_EN
        if (idle_cnt == TO) begin
          e_err = 1; frame.delete(); idle_cnt = 0;
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare + strobe log ----------------
  int         wr_cnt, rd_cnt, alu_cnt, err_cnt;
  logic [3:0] wr_log_addr[$];
  logic [7:0] wr_log_data[$];
  logic [3:0] last_rd_addr, last_fun;

  always @(negedge clk) begin
    check("wr_en", wr_en, e_wr);
    check("rd_en", rd_en, e_rd);
    check("alu_en", alu_en, e_alu);
    check("cmd_err", cmd_err, e_err);
    check("addr", addr, e_addr);
    check("wr_data", wr_data, e_data);
    check("alu_fun", alu_fun, e_fun);
    if (wr_en) begin
      wr_cnt++; wr_log_addr.push_back(addr); wr_log_data.push_back(wr_data);
    end
    if (rd_en) begin rd_cnt++; last_rd_addr = addr; end
    if (alu_en) begin alu_cnt++; last_fun = alu_fun; end
    if (cmd_err) err_cnt++;
  end

  task automatic clear_log();
    wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; err_cnt = 0;
    wr_log_addr.delete(); wr_log_data.delete();
    last_rd_addr = 0; last_fun = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_d_valid = 1'b1;
    rx_p_data  = b;
    @(posedge clk);
    #1;
    rx_d_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_d_valid = 1'b0; rx_p_data = 8'h00;
    clear_log();
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("reset_addr", addr, 0);
    check("reset_wr_data", wr_data, 0);

    // Write frame
    clear_log();
    send(8'hAA); idle(1); send(8'h05); idle(2); send(8'h3C); idle(3);
    check("wr_cnt", wr_cnt, 1);
    check("wr_addr", wr_log_addr.size() > 0 ? wr_log_addr[0] : 4'hF, 5);
    check("wr_data_lit", wr_log_data.size() > 0 ? wr_log_data[0] : 8'h00, 8'h3C);
    check("wr_others", rd_cnt + alu_cnt + err_cnt, 0);

    // Read frame, upper nibble of address dropped
    clear_log();
    send(8'hBB); send(8'h1A); idle(3);
    check("rd_cnt", rd_cnt, 1);
    check("rd_addr", last_rd_addr, 4'hA);
    check("rd_no_wr", wr_cnt, 0);

    // ALU with operands
    clear_log();
    send(8'hCC); send(8'h12); idle(1); send(8'h34); send(8'h01); idle(3);
    check("cc_wr_cnt", wr_cnt, 2);
    if (wr_cnt == 2) begin
      check("cc_a_addr", wr_log_addr[0], 0);
      check("cc_a_data", wr_log_data[0], 8'h12);
      check("cc_b_addr", wr_log_addr[1], 1);
      check("cc_b_data", wr_log_data[1], 8'h34);
    end
    check("cc_alu_cnt", alu_cnt, 1);
    check("cc_fun", last_fun, 1);

    // ALU function only, bad opcode, then a clean write
    clear_log();
    send(8'hDD); send(8'h03); idle(2);
    check("dd_alu_cnt", alu_cnt, 1);
    check("dd_fun", last_fun, 3);
    check("dd_no_wr", wr_cnt, 0);
    send(8'h55); idle(2);
    check("bad_op_err", err_cnt, 1);
    send(8'hAA); send(8'h02); send(8'hFF); idle(3);
    check("after_err_wr", wr_cnt, 1);
    check("after_err_addr", wr_log_addr.size() > 0 ? wr_log_addr[0] : 4'hF, 2);
    check("after_err_data", wr_log_data.size() > 0 ? wr_log_data[0] : 8'h00, 8'hFF);
    check("after_err_err", err_cnt, 1);

    // Reset mid-frame discards it; 3C becomes a bad opcode
    clear_log();
    send(8'hAA); send(8'h05); idle(1);
    rst_n = 1'b0; idle(2);
    check("midrst_addr", addr, 0);
    rst_n = 1'b1; idle(1);
    send(8'h3C); idle(3);
    check("midrst_wr", wr_cnt, 0);
    check("midrst_err", err_cnt, 1);

`ifdef RX_CMD_TIMEOUT_EN
    // Full idle gap aborts the frame
    clear_log();
    send(8'hAA); idle(TO); idle(3);
    check("tmo_err", err_cnt, 1);
    check("tmo_no_strobe", wr_cnt + rd_cnt + alu_cnt, 0);
    send(8'h3C); idle(2);
    check("tmo_back_idle", err_cnt, 2);
    // A byte in the expiry cycle is accepted
    clear_log();
    send(8'hAA); idle(TO - 1); send(8'h07); send(8'h44); idle(3);
    check("tmo_edge_err", err_cnt, 0);
    check("tmo_edge_wr", wr_cnt, 1);
    check("tmo_edge_addr", wr_log_addr.size() > 0 ? wr_log_addr[0] : 4'hF, 7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
